// File: rtl/fp16_sched_pkg.sv
// Shared types, constants and per-stage datapath functions for the scheduled
// FP16 relaxed add/sub unit (denormal inputs read as zero, truncation, no NaN/Inf).
package fp16_sched_pkg;

  localparam int FP16_W     = 16;
  localparam int PIPE_DEPTH = 5;
  // Tag id is sized for the largest supported requester count (8).
  localparam int TAG_ID_W   = 3;

  localparam logic [15:0] ONE   = 16'h3C00;
  localparam logic [15:0] TWO   = 16'h4000;
  localparam logic [15:0] THREE = 16'h4200;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } stage_tag_t;

  typedef struct packed {
    logic        sign;
    logic        eff_sub;
    logic [4:0]  exp;
    logic [10:0] big_man;
    logic [10:0] small_man;
    logic [4:0]  diff;
  } s0_t;

  typedef struct packed {
    logic        sign;
    logic        eff_sub;
    logic [4:0]  exp;
    logic [10:0] big_man;
    logic [10:0] small_al;
  } s1_t;

  typedef struct packed {
    logic        sign;
    logic [4:0]  exp;
    logic [11:0] sum;
  } s2_t;

  typedef struct packed {
    logic        sign;
    logic [4:0]  exp;
    logic [11:0] sum;
    logic        zero;
    logic [3:0]  shift;
  } s3_t;

  // S0: unpack, apply the subtract flag to y, order operands by magnitude.
  function automatic s0_t fp_s0(input logic [15:0] a, input logic [15:0] b, input logic sub);
    s0_t         r;
    logic        sign_b;
    logic        x_big;
    logic [10:0] man_a;
    logic [10:0] man_b;
    sign_b    = b[15] ^ sub;
    man_a     = (a[14:10] == 5'd0) ? 11'd0 : {1'b1, a[9:0]};
    man_b     = (b[14:10] == 5'd0) ? 11'd0 : {1'b1, b[9:0]};
    x_big     = (a[14:0] >= b[14:0]);
    r.sign    = x_big ? a[15] : sign_b;
    r.eff_sub = a[15] ^ sign_b;
    r.exp     = x_big ? a[14:10] : b[14:10];
    r.big_man = x_big ? man_a : man_b;
    r.small_man = x_big ? man_b : man_a;
    r.diff    = x_big ? (a[14:10] - b[14:10]) : (b[14:10] - a[14:10]);
    return r;
  endfunction

  // S1: align the smaller mantissa; shifted-out bits are discarded.
  function automatic s1_t fp_s1(input s0_t s);
    s1_t r;
    r.sign     = s.sign;
    r.eff_sub  = s.eff_sub;
    r.exp      = s.exp;
    r.big_man  = s.big_man;
    r.small_al = s.small_man >> s.diff;
    return r;
  endfunction

  // S2: magnitude add or subtract; big >= aligned small so the result is non-negative.
  function automatic s2_t fp_s2(input s1_t s);
    s2_t r;
    r.sign = s.sign;
    r.exp  = s.exp;
    r.sum  = s.eff_sub ? ({1'b0, s.big_man} - {1'b0, s.small_al})
                       : ({1'b0, s.big_man} + {1'b0, s.small_al});
    return r;
  endfunction

  // S3: zero detect and left-shift distance to bring the leading one to bit 10.
  function automatic s3_t fp_s3(input s2_t s);
    s3_t r;
    r.sign  = s.sign;
    r.exp   = s.exp;
    r.sum   = s.sum;
    r.zero  = (s.sum == 12'd0);
    r.shift = 4'd0;
    for (int p = 0; p < 11; p++) begin
      if (s.sum[p]) r.shift = 4'(10 - p);
    end
    return r;
  endfunction

  // S4: normalize and pack; underflow flushes to +0, exponent saturates at 31.
  function automatic logic [15:0] fp_s4(input s3_t s);
    logic signed [6:0] e;
    logic [10:0]       m;
    logic [15:0]       r;
    m = s.sum[10:0] << s.shift;
    if (s.sum[11]) e = $signed({2'b00, s.exp}) + 7'sd1;
    else           e = $signed({2'b00, s.exp}) - $signed({3'b000, s.shift});
    if (s.zero || e <= 7'sd0) begin
      r = 16'h0000;
    end else begin
      if (e > 7'sd31) e = 7'sd31;
      r = {s.sign, e[4:0], (s.sum[11] ? s.sum[10:1] : m[9:0])};
    end
    return r;
  endfunction

endpackage

// File: rtl/fp16_raddsub_sched_rr_arbiter.sv
// Pointer-rotated round-robin priority: the first requester at or after ptr wins.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               grant_valid
);

  int idx;

  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    idx         = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (i == idx && req[i] && !grant_valid) begin
          grant[i]    = 1'b1;
          grant_idx   = ID_W'(i);
          grant_valid = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fp16_raddsub_sched.sv
// Round-robin scheduler sharing one 5-stage FP16 add/sub pipeline among NUM_REQ
// requesters; an {valid,id} tag rides alongside each op to steer its result back.
module fp16_raddsub_sched
  import fp16_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [16*NUM_REQ-1:0]   req_a,
  input  logic [16*NUM_REQ-1:0]   req_b,
  input  logic [NUM_REQ-1:0]      req_sub,
  input  logic                    flush,
  output logic [NUM_REQ-1:0]      resp_valid,
  output logic [15:0]             resp_data,
  output logic                    busy
);

  // Handshake: an op is accepted in the cycle where req_valid[i] && req_ready[i];
  // the requester must hold operands until then. Results have no backpressure.

  logic [NUM_REQ-1:0] req_eligible;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic               grant_valid;
  logic [ID_W-1:0]    rr_ptr;

  logic [15:0] a_sel;
  logic [15:0] b_sel;
  logic        sub_sel;

  stage_tag_t tag0, tag1, tag2, tag3, out_tag;
  s0_t        s0_q;
  s1_t        s1_q;
  s2_t        s2_q;
  s3_t        s3_q;

  assign req_eligible = req_valid & {NUM_REQ{~flush & ~rst}};
  assign req_ready    = grant;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req         (req_eligible),
    .ptr         (rr_ptr),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  always_comb begin
    a_sel   = '0;
    b_sel   = '0;
    sub_sel = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        a_sel   = req_a[i*FP16_W +: FP16_W];
        b_sel   = req_b[i*FP16_W +: FP16_W];
        sub_sel = req_sub[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (grant_valid) begin
      rr_ptr <= (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + ID_W'(1);
    end
  end

  // Tag chain and result register. Flush kills every tag including the output
  // one; the result presented during the flush cycle itself is still seen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag0      <= '0;
      tag1      <= '0;
      tag2      <= '0;
      tag3      <= '0;
      out_tag   <= '0;
      resp_data <= '0;
    end else begin
      tag0.valid <= grant_valid;
      tag0.id    <= TAG_ID_W'(grant_idx);
      if (flush) begin
        tag1    <= '0;
        tag2    <= '0;
        tag3    <= '0;
        out_tag <= '0;
      end else begin
        tag1    <= tag0;
        tag2    <= tag1;
        tag3    <= tag2;
        out_tag <= tag3;
        if (tag3.valid) resp_data <= fp_s4(s3_q);
      end
    end
  end

  // Datapath payload needs no reset: it is only observed behind a valid tag.
  always_ff @(posedge clk) begin
    s0_q <= fp_s0(a_sel, b_sel, sub_sel);
    s1_q <= fp_s1(s0_q);
    s2_q <= fp_s2(s1_q);
    s3_q <= fp_s3(s2_q);
  end

  always_comb begin
    resp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (out_tag.valid && int'(out_tag.id) == i) resp_valid[i] = 1'b1;
    end
  end

  assign busy = tag0.valid | tag1.valid | tag2.valid | tag3.valid | out_tag.valid;

endmodule

// File: tb/tb_fp16_raddsub_sched.sv
// Scoreboard bench for fp16_raddsub_sched: directed scenarios plus random traffic
// checked against an integer-arithmetic FP16 model and a round-robin model.
module tb_fp16_raddsub_sched;

  localparam int N    = 4;
  localparam int IDW  = 2;
  localparam int W    = 40;   // {due_cycle[15:0], id[7:0], data[15:0]}

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [16*N-1:0] req_a;
  logic [16*N-1:0] req_b;
  logic [N-1:0]    req_sub;
  logic            flush;
  logic [N-1:0]    resp_valid;
  logic [15:0]     resp_data;
  logic            busy;

  logic [W-1:0] exp_q[$];
  int           cyc = 0;
  int           n_chk = 0;
  int           n_pass = 0;
  int           mdl_ptr = 0;
  logic [N-1:0] last_grant = '0;
  logic [15:0]  last_data = '0;

  fp16_raddsub_sched #(.NUM_REQ(N), .ID_W(IDW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_sub    (req_sub),
    .flush      (flush),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .busy       (busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(posedge rst) begin
    exp_q.delete();
    mdl_ptr    = 0;
    last_grant = '0;
    last_data  = '0;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- reference models ----------------
  function automatic logic [15:0] fp_ref(input logic [15:0] x, input logic [15:0] y, input logic sub);
    int ex, ey, mx, my, eb, d, mb, ms, r;
    logic sx, sy, sb;
    sx = x[15];
    sy = y[15] ^ sub;
    ex = int'(x[14:10]);
    ey = int'(y[14:10]);
    mx = (ex == 0) ? 0 : 1024 + int'(x[9:0]);
    my = (ey == 0) ? 0 : 1024 + int'(y[9:0]);
    if (x[14:0] >= y[14:0]) begin
      eb = ex; mb = mx; ms = my; sb = sx; d = ex - ey;
    end else begin
      eb = ey; mb = my; ms = mx; sb = sy; d = ey - ex;
    end
    for (int k = 0; k < d; k++) ms = ms / 2;
    r = (sx == sy) ? mb + ms : mb - ms;
    if (r == 0) return 16'h0000;
    while (r >= 2048) begin r = r / 2; eb++; end
    while (r < 1024) begin r = r * 2; eb--; end
    if (eb <= 0) return 16'h0000;
    if (eb > 31) eb = 31;
    return {sb, 5'(eb), 10'(r - 1024)};
  endfunction

  function automatic int arb_ref(input logic [N-1:0] req, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (req[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, req);
  endtask

  // ---------------- stimulus capture: arbitration model + expected queue ----------------
  always begin : capture
    int          g;
    logic [N-1:0] exp_ready;
    @(negedge clk);
    #1;
    if (!rst) begin
      g = arb_ref(flush ? '0 : req_valid, mdl_ptr);
      exp_ready = (g >= 0) ? N'(1 << g) : '0;
      check("req_ready", 32'(req_ready), 32'(exp_ready));
      last_grant = exp_ready;
      if (g >= 0) begin
        exp_q.push_back({16'(cyc + 5), 8'(g),
                         fp_ref(req_a[g*16 +: 16], req_b[g*16 +: 16], req_sub[g])});
        mdl_ptr = (g + 1) % N;
      end
      if (flush) begin
        while (exp_q.size() > 0 && int'(exp_q[$][39:24]) > cyc) void'(exp_q.pop_back());
      end
    end else begin
      last_grant = '0;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin : monitor
    logic [W-1:0] e;
    if (!rst) begin
      check("busy", 32'(busy), 32'(exp_q.size() > 0));
      if (resp_valid != '0) begin
        if (exp_q.size() == 0) begin
          check("resp_spurious", 32'(resp_valid), 32'h0);
        end else begin
          e = exp_q.pop_front();
          check("resp_valid", 32'(resp_valid), 32'(1 << e[23:16]));
          check("resp_data", 32'(resp_data), 32'(e[15:0]));
          check("resp_cycle", 32'(cyc), 32'(e[39:24]));
          last_data = e[15:0];
        end
      end else begin
        check("resp_data_hold", 32'(resp_data), 32'(last_data));
        if (exp_q.size() > 0 && int'(exp_q[0][39:24]) <= cyc) begin
          e = exp_q.pop_front();
          check("resp_valid", 32'(resp_valid), 32'(1 << e[23:16]));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b, input logic s);
    req_a[i*16 +: 16] = a;
    req_b[i*16 +: 16] = b;
    req_sub[i]        = s;
    req_valid[i]      = 1'b1;
  endtask

  task automatic drop_granted();
    for (int i = 0; i < N; i++) if (last_grant[i]) req_valid[i] = 1'b0;
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while (req_valid != '0 && k < budget) begin
      tick();
      drop_granted();
      k++;
    end
    check("drain_timeout", 32'(req_valid), 32'h0);
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic rand_op(input int i);
    logic [15:0] a, b;
    a = 16'($urandom);
    b = 16'($urandom);
    if ($urandom_range(0, 2) == 0) b[14:10] = a[14:10] + 5'($urandom_range(0, 2));
    set_op(i, a, b, 1'($urandom_range(0, 1)));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    rst = 1'b1; flush = 1'b0; req_valid = '0; req_a = '0; req_b = '0; req_sub = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_resp_valid", 32'(resp_valid), 32'h0);
    check("reset_resp_data", 32'(resp_data), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);

    // single add 1+1 from requester 0
    tick(); set_op(0, 16'h3C00, 16'h3C00, 1'b0);
    drain(4); idle(7);

    // subtract 3-1 from requester 2
    tick(); set_op(2, 16'h4200, 16'h3C00, 1'b1);
    drain(4); idle(7);

    // contention from rr_ptr=0
    do_reset();
    set_op(0, 16'h3C00, 16'h3C00, 1'b0);
    set_op(1, 16'h4200, 16'h3C00, 1'b1);
    set_op(2, 16'h4000, 16'h4200, 1'b0);
    set_op(3, 16'h3C00, 16'h4200, 1'b1);
    drain(8); idle(7);

    // back-to-back on requester 1, alternating 1+1 and 2-1
    tick(); set_op(1, 16'h3C00, 16'h3C00, 1'b0);
    for (int k = 1; k < 6; k++) begin
      tick();
      if (k % 2 == 1) set_op(1, 16'h4000, 16'h3C00, 1'b1);
      else            set_op(1, 16'h3C00, 16'h3C00, 1'b0);
    end
    tick(); req_valid[1] = 1'b0;
    idle(8);

    // flush with three ops in flight; the fourth op waits out the flush cycle
    tick(); set_op(0, 16'h3C00, 16'h3C00, 1'b0);
    tick(); set_op(0, 16'h4200, 16'h3C00, 1'b1);
    tick(); set_op(0, 16'h4000, 16'h4000, 1'b0);
    tick(); set_op(0, 16'h4200, 16'h4200, 1'b0); flush = 1'b1;
    tick(); flush = 1'b0;
    drain(4); idle(8);

    // async reset between edges with three ops in flight
    tick(); set_op(1, 16'h3C00, 16'h3C00, 1'b0);
    tick(); set_op(1, 16'h4200, 16'h3C00, 1'b1);
    tick(); set_op(1, 16'h4000, 16'h3C00, 1'b0);
    tick();
    set_op(0, 16'h3C00, 16'h4000, 1'b0);
    set_op(1, 16'h4200, 16'h4000, 1'b1);
    set_op(2, 16'h3C00, 16'h3C00, 1'b1);
    set_op(3, 16'h4000, 16'h4200, 1'b0);
    #3 rst = 1'b1;
    #1;
    check("async_rst_resp_valid", 32'(resp_valid), 32'h0);
    check("async_rst_busy", 32'(busy), 32'h0);
    check("async_rst_req_ready", 32'(req_ready), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    drain(8); idle(8);

    // random traffic with occasional flushes
    for (int c = 0; c < 400; c++) begin
      tick();
      drop_granted();
      flush = ($urandom_range(0, 19) == 0);
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 1) == 1) rand_op(i);
      end
    end
    tick(); drop_granted(); flush = 1'b0;
    drain(40); idle(8);

    check("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
